npu_mem_reader: RTL and testbench

Sequential read engine for the 512x8 NPU memory banks. It takes a base address and byte count, issues single-byte reads to the RAM port (we held low), and absorbs the RAM's one-cycle read latency. Bytes are delivered in address order on a valid/ready output stream. It is the read-side counterpart to the host write path into NPU memories, and feeds NPU datapath consumers or a readback DMA.

---
 rtl/npu_mem_reader.sv | 154 +++++++++++++++
 tb/tb_npu_mem_reader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_mem_reader.sv
// Sequential byte reader for the 512x8 NPU memory banks.
// Streams base..base+len-1 (mod DEPTH) out on a valid/ready port.
module npu_mem_reader #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 8,
    parameter int MEMSEL_W = 6,
    parameter int REGSEL_W = 9,
    parameter logic [MEMSEL_W-1:0] MEM_ADDR = 6'b000010
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [REGSEL_W-1:0] cfg_base,
    input  logic [REGSEL_W:0]   cfg_len,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [MEMSEL_W-1:0] mem_adr,
    output logic [REGSEL_W-1:0] reg_adr,
    output logic                we,
    input  logic [WIDTH-1:0]    rdata,
    output logic [WIDTH-1:0]    m_data,
    output logic                m_valid,
    input  logic                m_ready
);

    localparam int LEN_W = REGSEL_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [REGSEL_W-1:0] nxt_q, nxt_d;
    logic [REGSEL_W-1:0] last_q, last_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                inflight_q, inflight_d;
    logic                err_q, err_d;
    logic [WIDTH-1:0]    fifo_q [2];
    logic [WIDTH-1:0]    fifo_d [2];
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic [1:0]          fcnt_q, fcnt_d;

    logic len_ok;
    logic pop;
    logic push;
    logic issue;
    logic done_c;

    assign len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(DEPTH));
    assign pop    = (fcnt_q != 2'd0) && m_ready;
    assign push   = inflight_q;

    // A same-cycle pop frees a slot, so one byte per cycle is sustained
    // without ever letting FIFO plus in-flight read exceed two entries.
    assign issue = (state_q == S_RUN) && (cnt_q != '0) &&
                   (({1'b0, fcnt_q} + {2'b0, inflight_q}) <
                    (3'd2 + {2'b0, pop}));

    always_comb begin
        state_d    = state_q;
        nxt_d      = nxt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        inflight_d = issue;
        done_c     = 1'b0;
        fifo_d     = fifo_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        fcnt_d     = fcnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        nxt_d   = cfg_base;
                        cnt_d   = cfg_len;
                        state_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    last_d = nxt_q;
                    nxt_d  = nxt_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && (fcnt_q == 2'd1) && !inflight_q) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            fifo_d[wr_q] = rdata;
            wr_d         = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        fcnt_d = fcnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            nxt_q      <= '0;
            last_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            fcnt_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            nxt_q      <= nxt_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            fifo_q[0]  <= fifo_d[0];
            fifo_q[1]  <= fifo_d[1];
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_c;
    assign err     = err_q;
    assign mem_adr = MEM_ADDR;
    assign we      = 1'b0;
    assign reg_adr = issue ? nxt_q : last_q;
    assign m_valid = (fcnt_q != 2'd0);
    assign m_data  = fifo_q[rd_q];

endmodule

// File: tb/tb_npu_mem_reader.sv
// Directed bench for npu_mem_reader with a 512x8 synchronous RAM model.
// RAM[i] = i & 0xFF, so expected stream bytes are the low address bits.
module tb_npu_mem_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [8:0] cfg_base;
    logic [9:0] cfg_len;
    logic       busy;
    logic       done;
    logic       err;
    logic [5:0] mem_adr;
    logic [8:0] reg_adr;
    logic       we;
    logic [7:0] rdata;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    logic [7:0] ram [512];

    int checks = 0;
    int errors = 0;

    npu_mem_reader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_base (cfg_base),
        .cfg_len  (cfg_len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mem_adr  (mem_adr),
        .reg_adr  (reg_adr),
        .we       (we),
        .rdata    (rdata),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rdata <= ram[reg_adr];

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b err=%b want 000",
                     busy, done, err);
        end
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_stream m_valid=%b m_data=%h want 0/00",
                     m_valid, m_data);
        end
        checks++;
        if (reg_adr !== 9'h000 || mem_adr !== 6'b000010 || we !== 1'b0) begin
            errors++;
            $display("FAIL reset_ram reg_adr=%h mem_adr=%b we=%b want 000/000010/0",
                     reg_adr, mem_adr, we);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Launches a transfer and consumes it, checking order, stability,
    // lookahead and done timing inline.
    task automatic run_stream(input logic [8:0] base, input int len,
                              input bit rnd, input bit mid, input string tag);
        int         got = 0;
        int         cyc = 0;
        int         done_cyc = -1;
        int         first_cyc = -1;
        bit         stalled = 0;
        logic [7:0] held = 8'h00;
        logic [8:0] ahead;
        logic [7:0] exp;
        @(negedge clk);
        cfg_base = base;
        cfg_len  = 10'(len);
        start    = 1'b1;
        m_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (got < len && cyc < len * 4 + 20) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mid && cyc == 50) begin
                start    = 1'b1;
                cfg_base = 9'h000;
                cfg_len  = 10'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            checks++;
            if (busy !== 1'b1 || err !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy cyc=%0d busy=%b err=%b want 1/0",
                         tag, cyc, busy, err);
            end
            if (stalled) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== held) begin
                    errors++;
                    $display("FAIL %s_stable cyc=%0d v=%b d=%h want 1/%h",
                             tag, cyc, m_valid, m_data, held);
                end
            end
            if (m_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                ahead = reg_adr - base - 9'(got);
                checks++;
                if (ahead > 9'd2) begin
                    errors++;
                    $display("FAIL %s_ahead cyc=%0d reg_adr=%h consumed=%0d max 2 ahead",
                             tag, cyc, reg_adr, got);
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                exp = 8'(base + 9'(got));
                checks++;
                if (m_data !== exp) begin
                    errors++;
                    $display("FAIL %s_data byte=%0d got=%h want %h",
                             tag, got, m_data, exp);
                end
                got++;
                checks++;
                if (done !== (got == len)) begin
                    errors++;
                    $display("FAIL %s_done byte=%0d done=%b want %b",
                             tag, got, done, (got == len));
                end
                if (got == len) done_cyc = cyc;
            end else begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_done_idle cyc=%0d done=%b want 0",
                             tag, cyc, done);
                end
            end
            stalled = (m_valid === 1'b1) && (m_ready === 1'b0);
            held    = m_data;
            @(negedge clk);
            cyc++;
        end
        start   = 1'b0;
        m_ready = 1'b1;
        checks++;
        if (got != len) begin
            errors++;
            $display("FAIL %s_count got=%0d bytes want %0d", tag, got, len);
        end
        if (!rnd) begin
            checks++;
            if (first_cyc != 3 || done_cyc != len + 2) begin
                errors++;
                $display("FAIL %s_latency first=%0d done=%0d want 3/%0d",
                         tag, first_cyc, done_cyc, len + 2);
            end
        end
        #1;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_after busy=%b m_valid=%b done=%b want 000",
                     tag, busy, m_valid, done);
        end
    endtask

    task automatic test_basic();
        run_stream(9'h000, 4, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_wrap();
        run_stream(9'h1FE, 4, 1'b0, 1'b0, "wrap");
    endtask

    task automatic test_backpressure();
        run_stream(9'h010, 8, 1'b1, 1'b0, "bp");
        run_stream(9'h0F0, 24, 1'b1, 1'b0, "bp2");
    endtask

    task automatic test_illegal_len();
        logic [9:0] lens [2];
        logic [8:0] ra;
        lens[0] = 10'd0;
        lens[1] = 10'd513;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ra       = reg_adr;
            cfg_base = 9'h055;
            cfg_len  = lens[i];
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL illegal_err len=%0d err=%b busy=%b v=%b want 1/0/0",
                         lens[i], err, busy, m_valid);
            end
            checks++;
            if (reg_adr !== ra) begin
                errors++;
                $display("FAIL illegal_adr len=%0d reg_adr=%h want %h",
                         lens[i], reg_adr, ra);
            end
            @(negedge clk);
            #1;
            checks++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse len=%0d err=%b busy=%b want 0/0",
                         lens[i], err, busy);
            end
        end
    endtask

    task automatic test_full_depth();
        run_stream(9'h100, 512, 1'b0, 1'b1, "full");
    endtask

    task automatic test_reset_abort();
        int got = 0;
        @(negedge clk);
        cfg_base = 9'h000;
        cfg_len  = 10'd16;
        start    = 1'b1;
        m_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            #1;
            if (m_valid === 1'b1) got++;
            @(negedge clk);
        end
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL abort_pre got=%0d bytes want 3", got);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state v=%b busy=%b done=%b want 000",
                     m_valid, busy, done);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (m_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet c=%0d v=%b done=%b busy=%b want 000",
                         c, m_valid, done, busy);
            end
        end
        run_stream(9'h000, 2, 1'b0, 1'b0, "restart");
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 8'(i);
        start    = 1'b0;
        cfg_base = '0;
        cfg_len  = '0;
        m_ready  = 1'b1;
        rst_n    = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_illegal_len();
        test_full_depth();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
